// File: rtl/ff_excitation_decoder.sv
// Flip-flop excitation decoder: turns a stream of observed Q samples into the
// D/T/JK/SR inputs that would cause each (Q, Q+) transition, with transition counters.
module ff_excitation_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             q_valid,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             d,
  output logic             t,
  output logic             j,
  output logic             k,
  output logic             s,
  output logic             r,
  output logic             jx,
  output logic             kx,
  output logic             sx,
  output logic             rx,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             toggle_sat,
  output logic             hold_sat
);

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic       prev_q, prev_q_nxt;
  logic       vld_p0;
  logic [9:0] exc_p0;

  // Packed as {d, t, j, k, s, r, jx, kx, sx, rx}; masked bits are forced to 0.
  function automatic logic [9:0] decode(input logic q, input logic q_next);
    logic [9:0] v;
    case ({q, q_next})
      2'b00:   v = 10'b0000000101;
      2'b01:   v = 10'b1110100100;
      2'b10:   v = 10'b0101011000;
      default: v = 10'b1000001010;
    endcase
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign exc_p0 = decode(prev_q, q_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      prev_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      prev_q <= prev_q_nxt;
    end
  end

  // A flush with a valid sample restarts the pair chain from that sample.
  always_comb begin
    state_nxt  = state;
    prev_q_nxt = prev_q;
    vld_p0     = 1'b0;
    if (flush) begin
      if (q_valid) begin
        state_nxt  = PRIMED;
        prev_q_nxt = q_in;
      end else begin
        state_nxt  = EMPTY;
        prev_q_nxt = 1'b0;
      end
    end else if (q_valid) begin
      state_nxt  = PRIMED;
      prev_q_nxt = q_in;
      vld_p0     = (state == PRIMED);
    end
  end

  // Stage p0 -> outputs: register the decode; data holds between pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      {d, t, j, k, s, r, jx, kx, sx, rx} <= '0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        {d, t, j, k, s, r, jx, kx, sx, rx} <= exc_p0;
      end
    end
  end

  // exc_p0[8] is the toggle bit t.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
      hold_cnt   <= '0;
    end else if (cnt_clr) begin
      toggle_cnt <= '0;
      hold_cnt   <= '0;
    end else if (vld_p0) begin
      if (exc_p0[8]) begin
        toggle_cnt <= sat_inc(toggle_cnt);
      end else begin
        hold_cnt <= sat_inc(hold_cnt);
      end
    end
  end

  assign toggle_sat = &toggle_cnt;
  assign hold_sat   = &hold_cnt;

endmodule

// File: doc/ff_excitation_decoder.md
# ff_excitation_decoder

Reverse-direction companion to the team's flip-flop cells: the flip-flops map excitation inputs to a next state, and this block maps an observed state sequence back to excitation inputs. It samples a stream of flip-flop output values `q_in`. For each consecutive (Q, Q+) pair it emits the D, T, JK and SR excitation inputs that would produce that transition, plus don't-care masks. It also keeps saturating counts of toggle and hold transitions, and is used as a checker/monitor beside flip-flop instances and in test fixtures.

## Interface
- `CNT_W`, default 8: width of `toggle_cnt` and `hold_cnt`, minimum 2.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `q_in`  in  1  observed flip-flop output sample
- `q_valid`  in  1  `q_in` is a valid sample this cycle
- `flush`  in  1  synchronous; discard the stored previous sample
- `cnt_clr`  in  1  synchronous; clear both counters
- `out_valid`  out  1  excitation outputs valid (one-cycle pulse per decoded pair)
- `d`, `t`, `j`, `k`, `s`, `r`  out  1 each  excitation values
- `jx`, `kx`, `sx`, `rx`  out  1 each  don't-care mask; 1 = value is X, and the data bit is then driven 0
- `toggle_cnt`  out  `CNT_W`  count of Q≠Q+ pairs, saturating
- `hold_cnt`  out  `CNT_W`  count of Q=Q+ pairs, saturating
- `toggle_sat`, `hold_sat`  out  1 each  corresponding counter is at all-ones

## Operation
- FSM with 2 states:
  - EMPTY: no previous sample stored.
  - PRIMED: `prev_q` register holds the last valid sample.
- Transitions in EMPTY:
  - `q_valid`=1: store `q_in` into `prev_q`, go to PRIMED, produce no output.
- Transitions in PRIMED, with `q_valid`=1:
  - Decode the pair (Q=`prev_q`, Q+=`q_in`) and register the outputs.
  - Pulse `out_valid`.
  - Set `prev_q` ← `q_in` and stay in PRIMED.
- Decode table (all unlisted masks 0):
  - 0→0: d=0 t=0 j=0 kx=1 s=0 rx=1.
  - 0→1: d=1 t=1 j=1 kx=1 s=1 r=0.
  - 1→0: d=0 t=1 jx=1 k=1 s=0 r=1.
  - 1→1: d=1 t=0 jx=1 k=0 sx=1 r=0.
- Invariants: `d`=Q+ and `t`=Q xor Q+. Any bit whose mask is 1 is driven 0.
- Counters: a decoded pair with t=1 increments `toggle_cnt`; t=0 increments `hold_cnt`.
- Counter saturation: a counter holds at 2^CNT_W−1 and never wraps. Its `_sat` flag is combinational from the counter value.
- `cnt_clr` has priority over increment: a pair decoded in the same cycle is not counted. `out_valid` and decode still happen, and FSM/`prev_q` are unaffected.
- `flush`=1: go to EMPTY and clear `prev_q` to 0.
- `flush` and `q_valid` in the same cycle: `q_in` becomes the new first sample. Go to PRIMED with no output.
- `q_valid`=0: no state change. Decode outputs hold their last values; `out_valid`=0.

## Timing
- Reset (async, `rst_n`=0):
  - State EMPTY, `prev_q`=0, all counters 0.
  - `out_valid`=0 and every excitation/mask output 0. `_sat` flags read 0 (CNT_W≥2).
- Release of `rst_n` is taken synchronously to `clk`. Reset asserted mid-stream aborts immediately: no pending pair survives.
- Latency: the sample accepted at edge N decodes at edge N. `out_valid` and outputs are visible from edge N until edge N+1.
- Counters update at the same edge as `out_valid` rises.
- Throughput: one pair per cycle with `q_valid` held high. N consecutive valid samples after EMPTY give N−1 `out_valid` pulses.
- No backpressure: outputs are overwritten by the next decode.

## Test plan
- Reset then samples 0,1,1,0,0 on consecutive cycles → 4 pulses:
  - (d,t,j,k,s,r) = 1,1,1,0,1,0 with kx=1.
  - then 1,0,0,0,0,0 with jx=sx=1.
  - then 0,1,0,1,0,1 with jx=1.
  - then 0,0,0,0,0,0 with kx=rx=1.
  - Final counts: `toggle_cnt`=2, `hold_cnt`=2.
- Gaps: samples 1, idle 3 cycles, 0 → a single 1→0 pulse 4 cycles after the first sample; outputs held during idle and `out_valid`=0.
- `flush` with `q_valid`=1, `q_in`=1 mid-stream → no pulse that cycle. A next sample of 1 decodes as 1→1, not as a transition from the old `prev_q`.
- CNT_W=2, five toggling samples after the first → `toggle_cnt` reaches 3 and stays 3, `toggle_sat`=1. `cnt_clr` together with a hold pair → counters 0 and 0; that hold is not counted.
- Assert `rst_n`=0 asynchronously between edges mid-stream → outputs 0 immediately. After release, the first sample produces no pulse.
